// File: rtl/serial_add_if.sv
// Start/done handshake bundle between the control unit and the bit-serial adder.
// The acc_sel select exists only when SERIAL_ADD_ACC_EN is defined.
interface serial_add_if #(
    parameter int N = 16
);
    logic         start;
    logic [N-1:0] rs1;
    logic [N-1:0] rs2;
`ifdef SERIAL_ADD_ACC_EN
    logic         acc_sel;
`endif
    logic [N-1:0] rd;
    logic         carry;
    logic         overflow;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    // Handshake: start is sampled only while idle; an accepted start yields
    // exactly one done pulse N+1 cycles later. start seen while busy or done is dropped.
    modport master (
        output start, rs1, rs2,
`ifdef SERIAL_ADD_ACC_EN
        output acc_sel,
`endif
        input  rd, carry, overflow, busy, done, dbg_state
    );

    modport slave (
        input  start, rs1, rs2,
`ifdef SERIAL_ADD_ACC_EN
        input  acc_sel,
`endif
        output rd, carry, overflow, busy, done, dbg_state
    );
endinterface

// File: rtl/serial_add.sv
// Bit-serial adder rd = rs1 + rs2, one bit per clock LSB first, with carry and signed overflow.
// Optional accumulate mode (rd = rd + rs2) is enabled by defining SERIAL_ADD_ACC_EN.
module serial_add #(
    parameter int N     = 16,
    parameter int CNT_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_add_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-2:0]     sum_q, sum_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     rd_q, rd_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             s_bit;
    logic             c_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // One full-adder slice evaluated on the current LSBs.
    assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
    assign c_out = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef SERIAL_ADD_ACC_EN
                    a_d = bus.acc_sel ? rd_q : bus.rs1;
`else
                    a_d = bus.rs1;
`endif
                    b_d     = bus.rs2;
                    sum_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_out;
                // Sum bits enter at the top so bit k sits at sum_q[k] once N-1 bits are in.
                sum_d = (sum_q >> 1) | ((N-1)'(s_bit) << (N - 2));
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    rd_d    = {s_bit, sum_q};
                    carry_d = c_out;
                    ovf_d   = c_q ^ c_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rd        = rd_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.dbg_state = state_q;
endmodule

// File: doc/serial_add.md
Name: serial_add

Overview:
- Multi-cycle bit-serial adder for the CPU datapath, computing rd = rs1 + rs2 one bit per clock, LSB first.
- It is the additive counterpart of the combinational `sub` unit, used where area matters more than latency.
- Operands and result share the 16-bit register-operand width used by the ALU.
- Issued by a start/done handshake from the control unit.

Parameters:
- N, 16, operand/result width in bits (must be >= 2).
- CNT_W, $clog2(N), width of internal bit counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- rs1  input  N  operand A, captured in the cycle start is accepted.
- rs2  input  N  operand B, captured in the cycle start is accepted.
- acc_sel  input  1  accumulate select; present only when SERIAL_ADD_ACC_EN is defined.
- rd  output  N  sum[N-1:0]; holds last completed result.
- carry  output  1  carry out of bit N-1 of last result.
- overflow  output  1  signed (two's complement) overflow of last result.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd=0, carry=0, overflow=0, busy=0, done=0.
  - State=IDLE; internal shift registers, counter and carry flop cleared.
  - Reset mid-operation discards the in-flight add with no done pulse. Outputs stay at 0 until a new add completes.
- States: IDLE, RUN, DONE.
  - IDLE: if start=1 at a rising edge, latch a_sh=rs1, b_sh=rs2, c=0, cnt=0, go RUN. Otherwise stay. busy=0.
  - RUN: busy=1. Each edge:
    - s = a_sh[0]^b_sh[0]^c.
    - c <= majority(a_sh[0],b_sh[0],c).
    - a_sh, b_sh shift right by 1.
    - s is shifted into the MSB of internal sum_sh.
    - cnt increments.
  - RUN exit: at the edge where cnt==N-1 (the last bit), register the outputs, then go DONE:
    - rd <= {s, sum_sh[N-1:1]}.
    - carry <= carry-out of bit N-1.
    - overflow <= carry-in(bit N-1) ^ carry-out(bit N-1).
  - DONE: done=1 for exactly one cycle, busy=0. Next edge goes IDLE unconditionally.
- Latency and interface timing:
  - Start is sampled in cycle 0. RUN occupies cycles 1..N. done is high in cycle N+1 (N=16: cycle 17).
  - A new start is accepted in the cycle after DONE at the earliest (throughput 1 add per N+2 cycles).
  - start while in RUN or DONE is ignored, not queued.
  - rs1/rs2 may change freely after the accepting edge without affecting the result.
  - rd, carry and overflow change only at the RUN->DONE edge. They are stable in every other cycle, including during a subsequent RUN.
- Arithmetic: modulo 2^N unsigned sum. carry is the unsigned overflow bit. overflow is set when the operands have the same sign and the result's sign differs.
- busy and done are never high simultaneously.

Optional Feature:
- Macro SERIAL_ADD_ACC_EN.
- Defined: the acc_sel port exists.
  - If start is accepted with acc_sel=1, a_sh is loaded from the current rd instead of rs1, giving rd = rd + rs2.
  - carry-in remains 0.
  - acc_sel is sampled only with start.
- Not defined: the acc_sel port is absent and a_sh is always loaded from rs1.

Test Plan:
- Reset, then start with rs1=0x0001, rs2=0x0001: busy high cycles 1-16; done pulse in cycle 17; rd=0x0002, carry=0, overflow=0.
- rs1=0xFFFF, rs2=0x0001 -> rd=0x0000, carry=1, overflow=0.
- Signed overflow cases:
  - rs1=0x7FFF, rs2=0x0001 -> rd=0x8000, carry=0, overflow=1.
  - rs1=0x8000, rs2=0x8000 -> rd=0x0000, carry=1, overflow=1.
- Start 0x1234+0x1111, pulse start again with 0xFFFF+0xFFFF in cycle 5 and in the DONE cycle:
  - Both extra pulses are ignored.
  - rd=0x2345 and exactly one done pulse.
  - A start in the cycle after done is accepted.
- Start 0x00FF+0x0F0F, assert rst_n=0 in cycle 8:
  - All outputs 0 immediately; no done pulse.
  - A following 0x0003+0x0004 yields rd=0x0007.
- SERIAL_ADD_ACC_EN defined:
  - 0x0005+0x0003 -> rd=0x0008.
  - Then start with acc_sel=1, rs1=0xAAAA, rs2=0x0010 -> rd=0x0018.
